// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_pkg
//  Description : Shared types and constants for the MIPS instruction fetch
//                stage (state encoding, reset vector, word-alignment mask).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Boot address of the core; the PC comes out of reset here
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    // Clears the byte-offset bits to form a word address
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instruction_fetch
//  Description : Fetch stage. Reads one 32-bit instruction per PC value over
//                an Avalon-MM style read port, hands it to decode through a
//                valid/ready handshake, advances the PC once per fetched word
//                and stops on the halt address or on a misaligned PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    output logic        pc_cnt_en,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fetch_error
);

    fetch_state_t r_state;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_halted;
    logic         r_fetch_error;

    fetch_state_t w_start_state;
    logic         w_start_halt;
    logic         w_start_error;
    logic         w_read_done;

    // Bus strobe comes from state only, so decode's ready never reaches the bus
    assign avm_read    = (r_state == FETCH);
    assign avm_address = pc & WORD_MASK;
    assign w_read_done = (r_state == FETCH) && !avm_waitrequest;

    // The PC advances on the same edge that captures the returned word
    assign pc_cnt_en   = w_read_done;

    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign fetch_error = r_fetch_error;

    // Start check: halt address has priority over the misalignment error
    always_comb begin
        w_start_state = FETCH;
        w_start_halt  = 1'b0;
        w_start_error = 1'b0;
        if (pc == HALT_ADDR) begin
            w_start_state = HALTED;
            w_start_halt  = 1'b1;
        end else if (pc[1:0] != 2'b00) begin
            w_start_state = HALTED;
            w_start_halt  = 1'b1;
            w_start_error = 1'b1;
        end
    end

    // Fetch sequencer with registered instruction and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_en) begin
                        r_state <= w_start_state;
                        if (w_start_halt)  r_halted      <= 1'b1;
                        if (w_start_error) r_fetch_error <= 1'b1;
                    end
                end
                FETCH: begin
                    // A dropped fetch_en does not abandon an issued read
                    if (w_read_done) begin
                        r_instr       <= avm_readdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        if (fetch_en) begin
                            r_state <= w_start_state;
                            if (w_start_halt)  r_halted      <= 1'b1;
                            if (w_start_error) r_fetch_error <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                HALTED: begin
                    // Terminal; only drains a word that decode has not taken yet
                    if (instr_ready) r_instr_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : mips_instruction_fetch
`default_nettype wire

// File: tb/tb_mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_instruction_fetch
//  Description : Directed self-checking bench for mips_instruction_fetch.
//                Inputs change just after the falling edge; outputs are
//                checked 1 ns later, well before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instruction_fetch;
    import mips_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc;
    logic        pc_cnt_en;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic        fetch_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_instruction_fetch #(.HALT_ADDR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .pc              (pc),
        .pc_cnt_en       (pc_cnt_en),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .halted          (halted),
        .fetch_error     (fetch_error)
    );

    // Holds reset across two edges and releases it just after a falling edge;
    // the cycle following the release is cycle 0 (IDLE).
    task automatic do_reset(input logic [31:0] new_pc, input logic en,
                            input logic wait_req, input logic [31:0] rdata);
        @(negedge clk);
        rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = 32'h0; pc = RESET_VECTOR;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; pc = new_pc; fetch_en = en;
        avm_waitrequest = wait_req; avm_readdata = rdata;
        #1;
    endtask

    task automatic test_reset;
        do_reset(RESET_VECTOR, 1'b1, 1'b0, 32'h2402_000A);
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rst_avm_read got %b exp 0", avm_read); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 00000000", instr); end
        n_tests++; if ({halted, fetch_error} !== 2'b00) begin n_fail++; $display("FAIL rst_status got %b exp 00", {halted, fetch_error}); end
        n_tests++; if (pc_cnt_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_cnt_en got %b exp 0", pc_cnt_en); end
        // cycle 1: read issued at the reset vector, PC advance in the same cycle
        @(negedge clk); #1;
        n_tests++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL zw_read got %b exp 1", avm_read); end
        n_tests++; if (avm_address !== 32'hBFC0_0000) begin n_fail++; $display("FAIL zw_addr got %h exp bfc00000", avm_address); end
        n_tests++; if (pc_cnt_en !== 1'b1) begin n_fail++; $display("FAIL zw_cnt_en_c1 got %b exp 1", pc_cnt_en); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid_c1 got %b exp 0", instr_valid); end
        // cycle 2: word delivered
        @(negedge clk); pc = 32'hBFC0_0004; #1;
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid_c2 got %b exp 1", instr_valid); end
        n_tests++; if (instr !== 32'h2402_000A) begin n_fail++; $display("FAIL zw_instr got %h exp 2402000a", instr); end
        n_tests++; if (pc_cnt_en !== 1'b0) begin n_fail++; $display("FAIL zw_cnt_en_c2 got %b exp 0", pc_cnt_en); end
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL zw_read_c2 got %b exp 0", avm_read); end
    endtask

    task automatic test_waitrequest;
        int pulses = 0;
        do_reset(32'hBFC0_0010, 1'b1, 1'b1, 32'h8C22_0004);
        // cycles 1..4 in FETCH; waitrequest high for the first three
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            avm_waitrequest = (c < 4);
            #1;
            if (pc_cnt_en === 1'b1) pulses++;
            n_tests++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL wr_read c%0d got %b exp 1", c, avm_read); end
            n_tests++; if (avm_address !== 32'hBFC0_0010) begin n_fail++; $display("FAIL wr_addr c%0d got %h exp bfc00010", c, avm_address); end
            n_tests++; if (pc_cnt_en !== (c == 4)) begin n_fail++; $display("FAIL wr_cnt_en c%0d got %b exp %b", c, pc_cnt_en, (c == 4)); end
        end
        @(negedge clk); pc = 32'hBFC0_0014; #1;
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL wr_pulse_count got %0d exp 1", pulses); end
        n_tests++; if (instr_valid !== 1'b1 || instr !== 32'h8C22_0004) begin n_fail++; $display("FAIL wr_instr got %b/%h exp 1/8c220004", instr_valid, instr); end
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL wr_read_hold got %b exp 0", avm_read); end
    endtask

    // Runs straight after test_waitrequest: DUT is in HOLD with 8C220004
    task automatic test_hold_stall;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); instr_ready = 1'b0; avm_readdata = 32'hDEAD_BEEF; #1;
            n_tests++; if (instr !== 32'h8C22_0004 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL hs_instr c%0d got %b/%h exp 1/8c220004", c, instr_valid, instr); end
            n_tests++; if (avm_read !== 1'b0 || pc_cnt_en !== 1'b0) begin n_fail++; $display("FAIL hs_bus c%0d got read=%b cnt=%b exp 0/0", c, avm_read, pc_cnt_en); end
        end
        // ready cycle: still HOLD, no bus activity yet
        @(negedge clk); instr_ready = 1'b1; avm_readdata = 32'h0000_0020; #1;
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL hs_ready_read got %b exp 0", avm_read); end
        // refetch the cycle after ready, from the advanced PC
        @(negedge clk); instr_ready = 1'b0; #1;
        n_tests++; if (avm_read !== 1'b1 || avm_address !== 32'hBFC0_0014) begin n_fail++; $display("FAIL hs_refetch got %b/%h exp 1/bfc00014", avm_read, avm_address); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL hs_valid_clr got %b exp 0", instr_valid); end
        n_tests++; if (pc_cnt_en !== 1'b1) begin n_fail++; $display("FAIL hs_cnt_en got %b exp 1", pc_cnt_en); end
        @(negedge clk); #1;
        n_tests++; if (instr !== 32'h0000_0020 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL hs_new_instr got %b/%h exp 1/00000020", instr_valid, instr); end
    endtask

    // instr_ready tied high: one instruction every two cycles, then fetch_en
    // drops mid-read and the sequencer parks in IDLE.
    task automatic test_back_to_back;
        logic [31:0] words [3];
        words[0] = 32'h1111_0000; words[1] = 32'h2222_0004; words[2] = 32'h3333_0008;
        do_reset(32'hBFC0_0100, 1'b1, 1'b0, words[0]);
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); avm_readdata = words[k];
            if (k == 2) fetch_en = 1'b0;
            #1;
            n_tests++; if (avm_read !== 1'b1 || avm_address !== 32'hBFC0_0100 + 32'(4 * k)) begin n_fail++; $display("FAIL b2b_addr k%0d got %b/%h exp 1/%h", k, avm_read, avm_address, 32'hBFC0_0100 + 32'(4 * k)); end
            @(negedge clk); pc = 32'hBFC0_0100 + 32'(4 * (k + 1)); #1;
            n_tests++; if (instr !== words[k] || instr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_instr k%0d got %b/%h exp 1/%h", k, instr_valid, instr, words[k]); end
        end
        // fetch_en low: HOLD -> IDLE, no further reads
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_tests++; if (avm_read !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c%0d got read=%b valid=%b exp 0/0", c, avm_read, instr_valid); end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_halt;
        do_reset(32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk); pc = RESET_VECTOR; #1;
        n_tests++; if (halted !== 1'b1 || fetch_error !== 1'b0) begin n_fail++; $display("FAIL halt_status got %b/%b exp 1/0", halted, fetch_error); end
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL halt_read got %b exp 0", avm_read); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); instr_ready = c[0]; #1;
            n_tests++; if (avm_read !== 1'b0 || pc_cnt_en !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_terminal c%0d got read=%b cnt=%b halted=%b exp 0/0/1", c, avm_read, pc_cnt_en, halted); end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_misaligned;
        do_reset(32'hBFC0_0002, 1'b1, 1'b0, 32'h1234_5678);
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL mis_read_c0 got %b exp 0", avm_read); end
        @(negedge clk); #1;
        n_tests++; if (halted !== 1'b1 || fetch_error !== 1'b1) begin n_fail++; $display("FAIL mis_status got %b/%b exp 1/1", halted, fetch_error); end
        n_tests++; if (avm_read !== 1'b0 || pc_cnt_en !== 1'b0) begin n_fail++; $display("FAIL mis_bus got %b/%b exp 0/0", avm_read, pc_cnt_en); end
    endtask

    task automatic test_reset_mid_fetch;
        do_reset(RESET_VECTOR, 1'b1, 1'b1, 32'hAAAA_5555);
        @(negedge clk); #1;
        n_tests++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL rmf_read_pre got %b exp 1", avm_read); end
        // assert reset between edges: read must drop without waiting for a clock
        @(negedge clk); rst = 1'b1; #1;
        n_tests++; if (avm_read !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_abort got read=%b valid=%b exp 0/0", avm_read, instr_valid); end
        @(negedge clk); rst = 1'b0; avm_waitrequest = 1'b0; pc = RESET_VECTOR; #1;
        n_tests++; if (avm_read !== 1'b0) begin n_fail++; $display("FAIL rmf_idle got %b exp 0", avm_read); end
        @(negedge clk); #1;
        n_tests++; if (avm_read !== 1'b1 || avm_address !== 32'hBFC0_0000 || pc_cnt_en !== 1'b1) begin n_fail++; $display("FAIL rmf_restart got %b/%h/%b exp 1/bfc00000/1", avm_read, avm_address, pc_cnt_en); end
        @(negedge clk); #1;
        n_tests++; if (instr_valid !== 1'b1 || instr !== 32'hAAAA_5555) begin n_fail++; $display("FAIL rmf_instr got %b/%h exp 1/aaaa5555", instr_valid, instr); end
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; pc = RESET_VECTOR; avm_readdata = 32'h0;
        avm_waitrequest = 1'b0; instr_ready = 1'b0;
        test_reset();
        test_waitrequest();
        test_hold_stall();
        test_back_to_back();
        test_halt();
        test_misaligned();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mips_instruction_fetch
`default_nettype wire

// File: doc/mips_instruction_fetch.md
# mips_instruction_fetch

Fetch stage directly downstream of the program counter. Takes the current `pc` and issues a 32-bit instruction read on the memory bus, waiting through `avm_waitrequest` stalls. It hands the returned word to decode over a valid/ready handshake and pulses `pc_cnt_en` (the PC's `CntEn`) once per accepted instruction. It detects the halt address (0x00000000) and misaligned PCs and stops fetching in both cases.

## Interface
Parameters:
- `HALT_ADDR`, default 32'h0000_0000: PC value that stops the CPU.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_en`  in  1  core run enable.
- `pc`  in  32  current PC from `mips_program_counter`.
- `pc_cnt_en`  out  1  drives the PC's `CntEn`; combinational.
- `avm_address`  out  32  word-aligned fetch address.
- `avm_read`  out  1  read strobe.
- `avm_readdata`  in  32  read data; valid in the cycle `avm_read && !avm_waitrequest`.
- `avm_waitrequest`  in  1  slave stall.
- `instr`  out  32  fetched instruction, registered.
- `instr_valid`  out  1  `instr` holds an unconsumed word.
- `instr_ready`  in  1  decode accepts `instr`.
- `halted`  out  1  sticky; the CPU has stopped.
- `fetch_error`  out  1  sticky; a misaligned PC was seen.

## Operation
States: IDLE, FETCH, HOLD, HALTED.

- **Reset** (async, any state, including mid-read): state goes to IDLE.
  - `avm_read`, `instr_valid`, `halted` and `fetch_error` go to 0.
  - `instr` goes to 32'h0.
  - `avm_read` drops in the same cycle `rst` asserts. A bus read in progress is abandoned.
- **Start check**, applied when leaving IDLE (`fetch_en`=1) or HOLD (`instr_ready`=1 and `fetch_en`=1). Evaluated in priority order:
  1. `pc == HALT_ADDR` -> HALTED, `halted` set.
  2. `pc[1:0] != 0` -> HALTED, `halted` and `fetch_error` set.
  3. Otherwise -> FETCH.
- **IDLE**
  - `fetch_en`=0: stay in IDLE.
  - `fetch_en`=1: apply the start check.
- **FETCH**
  - `avm_read`=1 and `avm_address = {pc[31:2],2'b00}`, both held stable while `avm_waitrequest`=1.
  - On a cycle with `avm_waitrequest`=0:
    - `instr <= avm_readdata` and `instr_valid <= 1`.
    - `pc_cnt_en`=1 in that same cycle, so the PC advances on the same edge.
    - Next state is HOLD.
- **HOLD**
  - `avm_read`=0. `instr`/`instr_valid` stay stable until `instr_ready`=1.
  - On `instr_ready`=1:
    - `instr_valid` clears, unless it is reloaded by an immediate refetch.
    - `fetch_en`=1: apply the start check.
    - `fetch_en`=0: go to IDLE.
  - `pc` already holds the advanced value in HOLD, since `pc_cnt_en` fired on entry.
- **HALTED**
  - Terminal until reset.
  - `avm_read`=0 and `pc_cnt_en`=0.
  - An `instr` still pending stays valid until it is consumed once; `instr_valid` then clears.
- `fetch_en` dropping during FETCH does not abort the read. The word completes, and HOLD then goes to IDLE.
- `pc_cnt_en` is 0 in every state except the FETCH acceptance cycle. This keeps the PC's branch-delay sequencing exactly one advance per fetched instruction.

## Timing
- Zero-wait read:
  - IDLE with `fetch_en` at cycle 0.
  - `avm_read` high in cycle 1.
  - `instr_valid` high in cycle 2.
- Each waitrequest cycle adds one cycle of latency.
- Maximum throughput is one instruction per 2 cycles, with `instr_ready` tied high.
- `instr` and `instr_valid` are registered outputs.
- `pc_cnt_en`, `avm_read` and `avm_address` are combinational from state, `pc` and `avm_waitrequest`. No combinational path runs from `instr_ready` to the bus outputs.
- `halted` asserts one cycle after the start check fires.

## Structure
- `mips_fetch_pkg`:
  - enum `fetch_state_t` {IDLE, FETCH, HOLD, HALTED}.
  - constant `RESET_VECTOR` = 32'hBFC0_0000, for benches.
  - constant `WORD_MASK` = 32'hFFFF_FFFC.
- Single module; no sub-module is warranted.

## Test plan
1. Reset release with `pc`=BFC00000, `fetch_en`=1, zero wait, `avm_readdata`=0x2402000A -> `avm_address`=BFC00000 in cycle 1; `instr`=0x2402000A with valid in cycle 2; `pc_cnt_en` high exactly in cycle 1.
2. Waitrequest high for 3 cycles -> `avm_address` and `avm_read` stable for 4 cycles; a single `pc_cnt_en` pulse on the final cycle.
3. `instr_ready` low for 5 cycles in HOLD -> `instr` unchanged, no bus read, no `pc_cnt_en`; the refetch starts the cycle after ready.
4. `pc`=0x00000000 at the start check -> `halted`=1 with no bus read; `avm_read` never rises afterwards.
5. `pc`=BFC00002 -> `halted`=1, `fetch_error`=1, no read issued.
6. `rst` asserted mid-FETCH while waitrequest is high -> `avm_read`=0 immediately, `instr_valid`=0; the fetch restarts cleanly from BFC00000 after release.
